ram_sync_dp_clr: RTL and testbench

//   Parametrised synchronous RAM with two ports: a CPU read/write port (A) and a

---
 rtl/ram_pkg.sv | 13 +
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/ram_sync_dp_clr.sv | 94 +++++++++
 tb/tb_ram_sync_dp_clr.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared RAM package: clear-sequencer state encoding and the depth helper.
package ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } ram_state_e;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every address once, starting after reset or on a clr_req pulse.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam int unsigned DEPTH   = depth_of(AW);
    localparam logic [AW:0] CntLast = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CntOne  = (AW+1)'(1);

    ram_state_e    state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        clr_we  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // clr_req is deliberately ignored here so a running sweep never restarts.
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
        endcase
    end

    assign clr_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/ram_sync_dp_clr.sv
// Synchronous RAM: CPU read/write port A, read-only scan port B, built-in clear sweep.
// Define WRITE_THROUGH_EN for write-first collisions; default is read-first (old data).
module ram_sync_dp_clr
    import ram_pkg::*;
#(
    parameter int unsigned   AW      = 8,
    parameter int unsigned   DW      = 4,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] i,
    output logic [DW-1:0] d,
    input  logic          cs_n,
    input  logic          w_n,
    input  logic          oe_n,
    input  logic [AW-1:0] ra,
    input  logic          rcs_n,
    output logic [DW-1:0] rd,
    input  logic          clr_req,
    output logic          busy
);

    localparam int unsigned DEPTH = depth_of(AW);

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          we_a;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] a_rdata;
    logic [DW-1:0] b_rdata;
    logic [DW-1:0] d_q;
    logic [DW-1:0] rd_q;

    ram_clear_seq #(
        .AW (AW)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign we_a = ~cs_n & ~w_n & ~busy;

    // The sweep owns the single write port while busy; port A writes are dropped then.
    assign wr_en   = clr_we | we_a;
    assign wr_addr = clr_we ? clr_addr : a;
    assign wr_data = clr_we ? CLR_VAL : i;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        a_rdata = mem[a];
        b_rdata = mem[ra];
`ifdef WRITE_THROUGH_EN
        if (we_a) begin
            a_rdata = i;
        end
        if (we_a && (ra == a)) begin
            b_rdata = i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q  <= '0;
            rd_q <= '0;
        end else begin
            if (!cs_n) begin
                d_q <= busy ? CLR_VAL : a_rdata;
            end
            if (!rcs_n) begin
                rd_q <= busy ? CLR_VAL : b_rdata;
            end
        end
    end

    assign d  = oe_n ? '0 : d_q;
    assign rd = rd_q;

endmodule

// File: tb/tb_ram_sync_dp_clr.sv
// Randomized bench for ram_sync_dp_clr with a behavioural model and a scoreboard queue.
module tb_ram_sync_dp_clr;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 4;
    localparam int unsigned DEPTH = 256;
    localparam logic [3:0]  CLR   = 4'hA;
`ifdef WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    typedef struct {
        logic [3:0] d;
        logic [3:0] rd;
        logic       busy;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] a = '0;
    logic [3:0] i = '0;
    logic [3:0] d;
    logic       cs_n = 1'b1;
    logic       w_n = 1'b1;
    logic       oe_n = 1'b0;
    logic [7:0] ra = '0;
    logic       rcs_n = 1'b1;
    logic [3:0] rd;
    logic       clr_req = 1'b0;
    logic       busy;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_err = 0;
    string      phase = "init";

    // Reference state: memory contents, registered read values, words left in the sweep.
    logic [3:0] m_mem [DEPTH];
    logic [3:0] m_d = '0;
    logic [3:0] m_rd = '0;
    int         m_left = 0;

    ram_sync_dp_clr #(
        .AW      (AW),
        .DW      (DW),
        .CLR_VAL (CLR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .i       (i),
        .d       (d),
        .cs_n    (cs_n),
        .w_n     (w_n),
        .oe_n    (oe_n),
        .ra      (ra),
        .rcs_n   (rcs_n),
        .rd      (rd),
        .clr_req (clr_req),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string tag, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (%s) t=%0t: got %h want %h", nm, tag, $time, act, exp);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model across the coming edge.
    task automatic step(input logic rst, input logic clr, input logic cs, input logic wn,
                        input logic oe, input logic [7:0] av, input logic [3:0] iv,
                        input logic rcs, input logic [7:0] rav);
        exp_t e;
        bit   busy_now;
        bit   wr;
        @(negedge clk);
        reset = rst; clr_req = clr; cs_n = cs; w_n = wn; oe_n = oe;
        a = av; i = iv; rcs_n = rcs; ra = rav;
        if (rst) begin
            m_left = DEPTH;
            m_d    = '0;
            m_rd   = '0;
        end else begin
            busy_now = (m_left > 0);
            wr       = !cs && !wn && !busy_now;
            if (!cs)  m_d  = busy_now ? CLR : ((wr && WT) ? iv : m_mem[av]);
            if (!rcs) m_rd = busy_now ? CLR : ((wr && WT && rav == av) ? iv : m_mem[rav]);
            if (busy_now) begin
                m_mem[DEPTH - m_left] = CLR;
                m_left--;
            end else begin
                if (wr) m_mem[av] = iv;
                if (clr) m_left = DEPTH;
            end
        end
        e.d    = oe ? 4'h0 : m_d;
        e.rd   = m_rd;
        e.busy = (m_left > 0);
        e.tag  = phase;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
    endtask

    task automatic rand_step(input bit allow_clr);
        step(0, allow_clr && ($urandom_range(0, 149) == 0), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0), 8'($urandom), 4'($urandom), 1'($urandom),
             8'($urandom));
    endtask

    // Monitor: every edge produces a response; pop and compare it just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("busy", e.tag, {3'b000, busy}, {3'b000, e.busy});
                chk("d",    e.tag, d,  e.d);
                chk("rd",   e.tag, rd, e.rd);
            end
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) m_mem[k] = 4'h0;

        phase = "reset_sweep";
        step(1, 0, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 50) step(0, 0, 0, 0, 0, 8'h40, 4'h3, 0, 8'h40);
            else         rand_step(0);
        end
        phase = "post_sweep_read";
        step(0, 0, 0, 1, 0, 8'hFF, 4'h0, 0, 8'h00);
        step(0, 0, 0, 1, 0, 8'h40, 4'h0, 0, 8'h40);

        phase = "idle_rw";
        step(0, 0, 0, 0, 0, 8'h12, 4'h5, 1, 8'h00);
        step(0, 0, 0, 1, 0, 8'h12, 4'h0, 1, 8'h00);
        step(0, 0, 1, 1, 1, 8'h12, 4'h0, 1, 8'h00);

        phase = "collision";
        step(0, 0, 0, 0, 0, 8'h20, 4'h1, 1, 8'h00);
        step(0, 0, 0, 0, 0, 8'h20, 4'h7, 0, 8'h20);
        step(0, 0, 1, 1, 0, 8'h00, 4'h0, 0, 8'h20);

        phase = "random";
        for (int k = 0; k < 500; k++) rand_step(1);
        idle(DEPTH + 2);

        phase = "clr_during_sweep";
        step(0, 1, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
        idle(99);
        step(0, 1, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
        idle(DEPTH - 100 + 3);

        phase = "reset_mid_sweep";
        step(1, 0, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
        idle(100);
        step(1, 0, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
        for (int k = 0; k < DEPTH + 3; k++) rand_step(0);

        phase = "fill_then_clear";
        for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 0, 0, 8'(k), 4'h6, 1, 8'h00);
        step(0, 0, 0, 1, 0, 8'h33, 4'h0, 0, 8'hC4);
        step(0, 1, 1, 1, 0, 8'h00, 4'h0, 1, 8'h00);
        for (int k = 0; k < DEPTH; k++) rand_step(0);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 0, 1, 0, 8'(k), 4'h0, 0, 8'(DEPTH - 1 - k));

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
